// File: rtl/montar_senha.sv
// Purpose : collects keypad digits into a password packet, emitted on '#'
//           (or per key in direct mode); '*', timeout, enable low or a mode
//           change discard the partial entry.
// Latency : 1 cycle from the accepted key strobe to digitos_valid.
// Backpr. : none; keys are one-cycle strobes, and a direct-mode key that
//           arrives while a strobe is already out is dropped, so digitos_valid
//           never stays high on two consecutive cycles.
//
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous active-low reset
//   enable        collection allowed while high
//   modo_direto   1 = emit every accepted key on its own
//   tecla_valid   one-cycle key strobe
//   tecla_value   0x0-0x9 digit, 0xA '*', 0xB '#', 0xC-0xF ignored
//   digitos_value senhaPac_t digits, flattened: digits[i] = bits [4i+3:4i]
//                 (digits[0] newest, unused slots 0xF)
//   digitos_valid one-cycle strobe qualifying digitos_value
module montar_senha #(
    parameter int MAX_DIGITS  = 20,   // at least 2
    parameter int TIMEOUT_CYC = 5000  // at least 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    modo_direto,
    input  logic                    tecla_valid,
    input  logic [3:0]              tecla_value,
    output logic [4*MAX_DIGITS-1:0] digitos_value,
    output logic                    digitos_valid
);

    localparam int BW = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [BW-1:0] EMPTY    = '1;
    localparam logic [BW-5:0] FILL_HI  = '1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_DIGITS);
    localparam logic [TW-1:0] TMO      = TW'(TIMEOUT_CYC);
    localparam logic [3:0]    KEY_STAR = 4'hA;
    localparam logic [3:0]    KEY_HASH = 4'hB;

    typedef enum logic [1:0] {
        VAZIO,
        COLETA,
        EMITE
    } state_t;

    state_t        state;
    logic [BW-1:0] buffer;
    logic [CW-1:0] count;
    logic [TW-1:0] timer;
    logic          modo_prev;

    logic          key_used;
    logic          is_digit;
    logic          modo_chg;
    logic [BW-1:0] base_buf;
    logic [CW-1:0] base_cnt;
    logic [BW-1:0] shifted;
    logic [TW-1:0] timer_inc;

    // Codes 0xC-0xF are not "used" keys: they behave exactly like idle cycles.
    assign key_used  = tecla_valid && enable && (tecla_value <= KEY_HASH);
    assign is_digit  = (tecla_value <= 4'd9);
    assign modo_chg  = (modo_direto != modo_prev);

    // A mode change empties the buffer this very cycle; a key accepted in the
    // same cycle is then processed, under the new mode, on the empty buffer.
    assign base_buf  = modo_chg ? EMPTY : buffer;
    assign base_cnt  = modo_chg ? '0 : count;

    // Shifting up naturally pushes digits[MAX_DIGITS-1] (the oldest) out.
    assign shifted   = {base_buf[BW-5:0], tecla_value};

    assign timer_inc = (timer == TMO) ? timer : timer + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= VAZIO;
            buffer        <= EMPTY;
            count         <= '0;
            timer         <= '0;
            modo_prev     <= 1'b0;
            digitos_value <= EMPTY;
            digitos_valid <= 1'b0;
        end else begin
            digitos_valid <= 1'b0;
            modo_prev     <= modo_direto;

            if (!enable) begin
                // Any strobe registered last cycle is already on the output
                // and completes; only new work is cancelled.
                buffer <= EMPTY;
                count  <= '0;
                timer  <= '0;
                state  <= VAZIO;
            end else if (key_used && modo_direto) begin
                buffer <= base_buf;
                count  <= base_cnt;
                timer  <= '0;
                if (!digitos_valid) begin
                    digitos_value <= {FILL_HI, tecla_value};
                    digitos_valid <= 1'b1;
                    state         <= EMITE;
                end else begin
                    state <= (base_cnt == '0) ? VAZIO : COLETA;
                end
            end else if (key_used && is_digit) begin
                buffer <= shifted;
                count  <= (base_cnt == CNT_MAX) ? base_cnt : base_cnt + 1'b1;
                timer  <= '0;
                state  <= COLETA;
            end else if (key_used && (tecla_value == KEY_HASH) && (base_cnt != '0)) begin
                digitos_value <= base_buf;
                digitos_valid <= 1'b1;
                buffer        <= EMPTY;
                count         <= '0;
                timer         <= '0;
                state         <= EMITE;
            end else if (modo_chg || (key_used && (tecla_value == KEY_STAR))) begin
                buffer <= EMPTY;
                count  <= '0;
                timer  <= '0;
                state  <= VAZIO;
            end else begin
                // Idle cycle (includes '#' on an empty buffer).
                case (state)
                    COLETA: begin
                        // Expire on the cycle the count reaches the limit, so a
                        // key one cycle later already finds the buffer empty.
                        if (timer_inc == TMO) begin
                            buffer <= EMPTY;
                            count  <= '0;
                            timer  <= '0;
                            state  <= VAZIO;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    EMITE: begin
                        timer <= '0;
                        state <= (count == '0) ? VAZIO : COLETA;
                    end
                    default: begin
                        timer <= '0;
                        state <= VAZIO;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_montar_senha.sv
module tb_montar_senha;

    localparam int MD  = 20;
    localparam int TMO = 10;
    localparam int BW  = 4 * MD;
    localparam logic [BW-1:0] ALL_F = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          modo_direto;
    logic          tecla_valid;
    logic [3:0]    tecla_value;
    logic [BW-1:0] digitos_value;
    logic          digitos_valid;

    int   tests    = 0;
    int   fails    = 0;
    int   emit_cnt = 0;
    logic prev_vld = 1'b0;

    always #5 clk = ~clk;

    montar_senha #(
        .MAX_DIGITS (MD),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .modo_direto  (modo_direto),
        .tecla_valid  (tecla_valid),
        .tecla_value  (tecla_value),
        .digitos_value(digitos_value),
        .digitos_valid(digitos_valid)
    );

    typedef struct {
        logic          modo;
        logic [3:0]    key;
        logic          exp_vld;
        logic [BW-1:0] exp_val;
    } vec_t;

    vec_t vt[21];

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] one_digit(input logic [3:0] d);
        logic [BW-1:0] v;
        v      = ALL_F;
        v[3:0] = d;
        return v;
    endfunction

    // Key strobe for one clock; returns 1 time unit after the sampling edge.
    task automatic press(input logic [3:0] k);
        tecla_value = k;
        tecla_valid = 1'b1;
        @(posedge clk);
        #1;
        tecla_valid = 1'b0;
        tecla_value = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Emission counter and back-to-back strobe detector, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            prev_vld = 1'b0;
        end else begin
            if (digitos_valid) begin
                emit_cnt++;
                tests++;
                if (prev_vld) begin
                    fails++;
                    $display("FAIL back_to_back_valid: got 1 on consecutive cycles expected 0");
                end
            end
            prev_vld = digitos_valid;
        end
    end

    initial begin
        logic [BW-1:0] v1234;
        logic [BW-1:0] exp21;
        int            base;

        v1234        = ALL_F;
        v1234[15:0]  = 16'h1234;

        //        modo  key   vld   value (held between emissions)
        vt[0]  = '{1'b0, 4'h1, 1'b0, ALL_F};
        vt[1]  = '{1'b0, 4'h2, 1'b0, ALL_F};
        vt[2]  = '{1'b0, 4'h3, 1'b0, ALL_F};
        vt[3]  = '{1'b0, 4'h4, 1'b0, ALL_F};
        vt[4]  = '{1'b0, 4'hB, 1'b1, v1234};
        vt[5]  = '{1'b0, 4'h5, 1'b0, v1234};
        vt[6]  = '{1'b0, 4'h6, 1'b0, v1234};
        vt[7]  = '{1'b0, 4'hA, 1'b0, v1234};
        vt[8]  = '{1'b0, 4'h7, 1'b0, v1234};
        vt[9]  = '{1'b0, 4'hB, 1'b1, one_digit(4'h7)};
        vt[10] = '{1'b0, 4'hB, 1'b0, one_digit(4'h7)};
        vt[11] = '{1'b0, 4'hC, 1'b0, one_digit(4'h7)};
        vt[12] = '{1'b0, 4'hB, 1'b0, one_digit(4'h7)};
        vt[13] = '{1'b1, 4'h1, 1'b1, one_digit(4'h1)};
        vt[14] = '{1'b1, 4'h0, 1'b1, one_digit(4'h0)};
        vt[15] = '{1'b1, 4'hA, 1'b1, one_digit(4'hA)};
        vt[16] = '{1'b1, 4'hB, 1'b1, one_digit(4'hB)};
        vt[17] = '{1'b1, 4'hD, 1'b0, one_digit(4'hB)};
        vt[18] = '{1'b0, 4'hC, 1'b0, one_digit(4'hB)};
        vt[19] = '{1'b0, 4'h9, 1'b0, one_digit(4'hB)};
        vt[20] = '{1'b0, 4'hB, 1'b1, one_digit(4'h9)};

        rst         = 1'b0;
        enable      = 1'b1;
        modo_direto = 1'b0;
        tecla_valid = 1'b0;
        tecla_value = 4'h0;

        #23;
        chk("reset_value", digitos_value, ALL_F);
        chk("reset_valid", BW'(digitos_valid), BW'(0));
        rst = 1'b1;
        idle(1);

        for (int i = 0; i < 21; i++) begin
            modo_direto = vt[i].modo;
            press(vt[i].key);
            chk($sformatf("vec%0d_valid", i), BW'(digitos_valid), BW'(vt[i].exp_vld));
            chk($sformatf("vec%0d_value", i), digitos_value, vt[i].exp_val);
            idle(1);
        end
        chk_int("emits_after_table", emit_cnt, 7);

        // 21 digits back to back: oldest one falls off the top.
        modo_direto = 1'b0;
        for (int k = 0; k < 21; k++) press(4'(k % 10));
        press(4'hB);
        exp21 = ALL_F;
        for (int i = 0; i < MD; i++) exp21[4*i +: 4] = 4'((20 - i) % 10);
        chk("overflow_valid", BW'(digitos_valid), BW'(1));
        chk("overflow_value", digitos_value, exp21);
        chk("overflow_d0", BW'(digitos_value[3:0]), BW'(0));
        chk("overflow_d19", BW'(digitos_value[4*19 +: 4]), BW'(1));
        idle(1);

        // Timeout: 10 idle cycles discard, 9 do not.
        base = emit_cnt;
        press(4'h8);
        idle(TMO);
        press(4'hB);
        chk("timeout_valid", BW'(digitos_valid), BW'(0));
        idle(1);
        chk_int("timeout_no_emit", emit_cnt, base);
        press(4'h8);
        idle(TMO - 1);
        press(4'hB);
        chk("pre_timeout_valid", BW'(digitos_valid), BW'(1));
        chk("pre_timeout_value", digitos_value, one_digit(4'h8));
        idle(1);

        // Reset pulse between clock edges in the middle of an entry.
        base = emit_cnt;
        press(4'h9);
        press(4'h9);
        rst = 1'b0;
        #2;
        chk("midreset_value", digitos_value, ALL_F);
        chk("midreset_valid", BW'(digitos_valid), BW'(0));
        #1;
        rst = 1'b1;
        #1;
        press(4'hB);
        chk("after_reset_valid", BW'(digitos_valid), BW'(0));
        chk("after_reset_value", digitos_value, ALL_F);
        idle(1);
        chk_int("after_reset_no_emit", emit_cnt, base);
        press(4'h3);
        press(4'hB);
        chk("resume_valid", BW'(digitos_valid), BW'(1));
        chk("resume_value", digitos_value, one_digit(4'h3));
        idle(1);

        // enable low discards the entry and drops the key of that cycle.
        press(4'h4);
        press(4'h5);
        enable = 1'b0;
        press(4'h6);
        enable = 1'b1;
        press(4'hB);
        chk("enable_drop_valid", BW'(digitos_valid), BW'(0));
        chk("enable_drop_value", digitos_value, one_digit(4'h3));
        idle(1);

        // A strobe already registered completes even if enable falls.
        press(4'h7);
        press(4'hB);
        enable = 1'b0;
        chk("enable_late_valid", BW'(digitos_valid), BW'(1));
        idle(1);
        chk("enable_late_cleared", BW'(digitos_valid), BW'(0));
        chk("enable_late_hold", digitos_value, one_digit(4'h7));
        enable = 1'b1;
        idle(2);

        chk_int("total_emits", emit_cnt, 11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
